usr_sequencer: RTL and testbench
================================

USR_SEQUENCER -- requirements
Module: usr_sequencer

Interface
REQ-001 The block SHALL have these ports:
  clk        input   1  rising-edge clock
  reset      input   1  asynchronous, active-low reset
  cmd_valid  input   1  command present
  cmd_ready  output  1  block can accept a command
  cmd_op     input   2  00 nop, 01 parallel load, 10 shift left, 11 shift right
  cmd_data   input   4  load word, used when cmd_op=01
  cmd_count  input   3  number of shifts, 0..7
  cmd_fill   input   1  serial fill bit for shifts
  cmd_rot    input   1  rotate request; see Configuration
  usr_q      input   4  present contents of the downstream universal shift register
  sel1       output  1  register mode select, MSB
  sel0       output  1  register mode select, LSB
  par_out    output  4  parallel load word to the register
  ser_l      output  1  serial input used in shift-left mode
  ser_r      output  1  serial input used in shift-right mode
  busy       output  1  command in progress
  done       output  1  single-cycle completion pulse
REQ-002 The block SHALL register every output; no output SHALL depend combinationally on any input.

Function
REQ-003 The mode encoding on {sel1,sel0} SHALL be: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
REQ-004 The state machine SHALL have four states: IDLE, LOAD, SHIFT and DONE.
REQ-005 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1.
REQ-006 On acceptance the block SHALL capture cmd_op, cmd_data, cmd_count, cmd_fill and cmd_rot, then change state:
  - cmd_op=01 -> LOAD
  - cmd_op=10 or 11 with cmd_count!=0 -> SHIFT
  - cmd_op=00, or cmd_count=0 on a shift op -> DONE
REQ-007 On the acceptance edge, cmd_ready SHALL drop to 0 and busy SHALL rise to 1.
REQ-008 LOAD SHALL last exactly one cycle with {sel1,sel0}=11 and par_out=captured data, then go to DONE.
REQ-009 SHIFT SHALL last exactly the captured count cycles:
  - {sel1,sel0}=01 for shift left, 10 for shift right
  - a 3-bit down-counter SHALL be loaded with count and decremented each cycle
  - exit to DONE after the cycle in which the counter equals 1.
REQ-010 During SHIFT the active serial output SHALL carry the fill bit: ser_l for shift left, ser_r for shift right. The inactive serial output SHALL be 0.
REQ-011 In DONE:
  - {sel1,sel0}=00, done=1 and busy=1 for exactly one cycle
  - next state is IDLE, with busy=0 and cmd_ready=1.
REQ-012 In IDLE, {sel1,sel0} SHALL be 00; par_out SHALL hold its last value; ser_l and ser_r SHALL be 0.
REQ-013 cmd_valid, and every cmd_* input, SHALL be ignored whenever cmd_ready=0. Commands are never queued.
REQ-014 Throughput: at most one command per (cycles in LOAD or SHIFT + 2).

Reset
REQ-015 While reset=0, the block SHALL hold:
  - state=IDLE, counter=0
  - sel1=sel0=0, par_out=0000, ser_l=ser_r=0
  - busy=0, done=0, cmd_ready=0.
REQ-016 cmd_ready SHALL become 1 on the first rising clk edge after reset deasserts.
REQ-017 Reset asserted mid-command SHALL abort the command immediately, asynchronously, with no done pulse.

Configuration
REQ-018 With ROTATE_EN defined, a shift command captured with cmd_rot=1 SHALL ignore the fill bit and drive the serial input from the live register value each SHIFT cycle:
  - shift left: ser_l = usr_q[3]
  - shift right: ser_r = usr_q[0]
REQ-019 Without ROTATE_EN, cmd_rot and usr_q SHALL be ignored and the fill bit SHALL always be used. The port list SHALL be identical in both builds.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  - Load: op=01, data=1010 -> one cycle of sel=11 with par_out=1010, then done pulse next cycle; accept-to-done = 2 edges.
  - Shift-left count: op=10, count=3, fill=1 -> sel=01 with ser_l=1 for exactly 3 cycles, then done; busy high for 4 cycles.
  - Zero-count shift: op=11, count=0 -> no shift cycle; done on the cycle after acceptance; sel stays 00.
  - Back-pressure: cmd_valid held high with changing data during a 5-shift command -> only the first command executes; the second is accepted in the cycle after done.
  - Reset mid-shift: reset=0 during cycle 2 of a 6-shift command -> all outputs go to reset values at once, no done pulse, cmd_ready=1 one edge after release.
  - Rotate, ROTATE_EN build: usr_q modelled as a 4-bit register loaded with 1000, op=10, count=4, rot=1 -> ser_l follows usr_q[3]; register returns to 1000. Non-ROTATE_EN build with the same stimulus uses the fill bit instead.

Source files
------------

// File: rtl/usr_sequencer.sv
// Command sequencer driving a 4-bit universal shift register (hold/shl/shr/load).
// Define ROTATE_EN to let shift commands rotate using the live register value.
module usr_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_data,
  input  logic [2:0] cmd_count,
  input  logic       cmd_fill,
  input  logic       cmd_rot,
  input  logic [3:0] usr_q,
  output logic       sel1,
  output logic       sel0,
  output logic [3:0] par_out,
  output logic       ser_l,
  output logic       ser_r,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t     r_state, w_next;
  logic [2:0] r_cnt, w_cnt;
  logic       r_left, w_left;
  logic       r_fill, w_fill;
  logic [1:0] r_sel, w_sel;
  logic [3:0] r_par, w_par;
  logic       r_serl, w_serl;
  logic       r_serr, w_serr;
  logic       r_busy, w_busy;
  logic       r_done, w_done;
  logic       r_ready, w_ready;
  logic       w_accept;
  logic       w_is_load;
  logic       w_is_shift;
  logic       w_bit_acc;
  logic       w_bit_run;

  assign w_accept   = (r_state == S_IDLE) & r_ready & cmd_valid;
  assign w_is_load  = (cmd_op == 2'b01);
  assign w_is_shift = cmd_op[1] & (cmd_count != 3'd0);

`ifdef ROTATE_EN
  logic r_rot, w_rot;

  assign w_rot = w_accept ? cmd_rot : r_rot;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rot <= 1'b0;
    else        r_rot <= w_rot;
  end

  // ser_* is registered on the same edge the register shifts, so in
  // SHIFT look one bit inward to get the end bit after that shift.
  assign w_bit_acc = cmd_rot ?
    ((cmd_op == 2'b10) ? usr_q[3] : usr_q[0]) : cmd_fill;
  assign w_bit_run = r_rot ?
    (r_left ? usr_q[2] : usr_q[1]) : r_fill;
`else
  logic w_unused_rot;

  assign w_unused_rot = ^{cmd_rot, usr_q};
  assign w_bit_acc    = cmd_fill;
  assign w_bit_run    = r_fill;
`endif

  always_comb begin
    w_next  = r_state;
    w_cnt   = r_cnt;
    w_left  = r_left;
    w_fill  = r_fill;
    w_sel   = 2'b00;
    w_par   = r_par;
    w_serl  = 1'b0;
    w_serr  = 1'b0;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    w_ready = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_busy  = 1'b0;
        w_ready = 1'b1;
        if (w_accept) begin
          w_busy  = 1'b1;
          w_ready = 1'b0;
          w_left  = (cmd_op == 2'b10);
          w_fill  = cmd_fill;
          unique case (1'b1)
            w_is_load: begin
              w_next = S_LOAD;
              w_sel  = 2'b11;
              w_par  = cmd_data;
            end
            w_is_shift: begin
              w_next = S_SHIFT;
              w_cnt  = cmd_count;
              w_sel  = cmd_op[0] ? 2'b10 : 2'b01;
              w_serl = ~cmd_op[0] & w_bit_acc;
              w_serr = cmd_op[0] & w_bit_acc;
            end
            default: begin
              w_next = S_DONE;
              w_done = 1'b1;
            end
          endcase
        end
      end
      S_LOAD: begin
        w_next = S_DONE;
        w_done = 1'b1;
      end
      S_SHIFT: begin
        w_cnt = r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          w_next = S_DONE;
          w_done = 1'b1;
        end else begin
          w_sel  = r_left ? 2'b01 : 2'b10;
          w_serl = r_left & w_bit_run;
          w_serr = ~r_left & w_bit_run;
        end
      end
      S_DONE: begin
        w_next  = S_IDLE;
        w_busy  = 1'b0;
        w_ready = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_left  <= 1'b0;
      r_fill  <= 1'b0;
      r_sel   <= 2'b00;
      r_par   <= 4'd0;
      r_serl  <= 1'b0;
      r_serr  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_left  <= w_left;
      r_fill  <= w_fill;
      r_sel   <= w_sel;
      r_par   <= w_par;
      r_serl  <= w_serl;
      r_serr  <= w_serr;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_ready <= w_ready;
    end
  end

  assign cmd_ready = r_ready;
  assign sel1      = r_sel[1];
  assign sel0      = r_sel[0];
  assign par_out   = r_par;
  assign ser_l     = r_serl;
  assign ser_r     = r_serr;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_usr_sequencer.sv
// Bench for usr_sequencer: directed scenarios plus random commands
// checked against a per-command cycle trace built from the command rules.
module tb_usr_sequencer;

`ifdef ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_data = 4'd0;
  logic [2:0] cmd_count = 3'd0;
  logic       cmd_fill = 1'b0;
  logic       cmd_rot = 1'b0;
  logic [3:0] q = 4'd0;
  logic       cmd_ready, sel1, sel0, ser_l, ser_r, busy, done;
  logic [3:0] par_out;

  int         checks = 0;
  int         failures = 0;
  logic [3:0] m_par = 4'd0;

  usr_sequencer dut (
    .clk(clk), .reset(rst_n), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_count(cmd_count), .cmd_fill(cmd_fill), .cmd_rot(cmd_rot),
    .usr_q(q), .sel1(sel1), .sel0(sel0), .par_out(par_out),
    .ser_l(ser_l), .ser_r(ser_r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // downstream universal shift register
  always @(posedge clk) begin
    case ({sel1, sel0})
      2'b01:   q <= {q[2:0], ser_l};
      2'b10:   q <= {ser_r, q[3:1]};
      2'b11:   q <= par_out;
      default: q <= q;
    endcase
  end

  function automatic logic [10:0] obs();
    return {sel1, sel0, par_out, ser_l, ser_r, busy, done, cmd_ready};
  endfunction

  task automatic drive_random();
    cmd_valid = 1'b1;
    cmd_op    = 2'($urandom_range(3));
    cmd_data  = 4'($urandom_range(15));
    cmd_count = 3'($urandom_range(7));
    cmd_fill  = 1'($urandom_range(1));
    cmd_rot   = 1'($urandom_range(1));
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] data,
                         input logic [2:0] cnt, input logic fill,
                         input logic rot, input bit hold,
                         input string tag);
    int         n;
    int         guard;
    logic       left;
    logic       b;
    logic [10:0] e;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_wait got=%b exp=1", tag, cmd_ready);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = cnt;
    cmd_fill  = fill;
    cmd_rot   = rot;
    left = (op == 2'b10);
    n = (op == 2'b01) ? 1 : ((op[1] && cnt != 3'd0) ? int'(cnt) : 0);
    if (op == 2'b01) m_par = data;
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (hold) drive_random();
      else cmd_valid = 1'b0;
      if (k == n) begin
        e = {2'b00, m_par, 2'b00, 3'b110};
      end else if (k == n + 1) begin
        e = {2'b00, m_par, 2'b00, 3'b001};
      end else if (op == 2'b01) begin
        e = {2'b11, data, 2'b00, 3'b100};
      end else begin
        b = (ROT && rot) ? (left ? q[3] : q[0]) : fill;
        e = {left ? 2'b01 : 2'b10, m_par, left & b, ~left & b, 3'b100};
      end
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL %s cyc%0d got=%b exp=%b", tag, k, obs(), e);
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (obs() !== 11'd0) begin
      failures++;
      $display("FAIL reset_hold got=%b exp=%b", obs(), 11'd0);
    end
    @(negedge clk);
    checks++;
    if (obs() !== 11'd0) begin
      failures++;
      $display("FAIL reset_edge got=%b exp=%b", obs(), 11'd0);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_ready got=%b exp=0", cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (obs() !== 11'b00000000001) begin
      failures++;
      $display("FAIL reset_first_edge got=%b exp=%b", obs(), 11'b1);
    end
  endtask

  task automatic test_load();
    run_cmd(2'b01, 4'b1010, 3'd0, 1'b0, 1'b0, 1'b0, "load");
  endtask

  task automatic test_shift_left();
    run_cmd(2'b10, 4'b0000, 3'd3, 1'b1, 1'b0, 1'b0, "shl3");
    run_cmd(2'b11, 4'b0110, 3'd2, 1'b1, 1'b0, 1'b0, "shr2");
  endtask

  task automatic test_zero_count();
    run_cmd(2'b11, 4'b1111, 3'd0, 1'b1, 1'b0, 1'b0, "zero_cnt");
    run_cmd(2'b00, 4'b0011, 3'd5, 1'b1, 1'b0, 1'b0, "nop");
  endtask

  task automatic test_back_to_back();
    run_cmd(2'b10, 4'b0000, 3'd5, 1'b1, 1'b0, 1'b1, "bp_first");
    run_cmd(2'b01, 4'b0101, 3'd0, 1'b0, 1'b0, 1'b0, "bp_second");
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_data  = 4'd0;
    cmd_count = 3'd6;
    cmd_fill  = 1'b1;
    cmd_rot   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 11'd0) begin
      failures++;
      $display("FAIL rst_mid_async got=%b exp=%b", obs(), 11'd0);
    end
    m_par = 4'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (obs() !== 11'd0) begin
        failures++;
        $display("FAIL rst_mid_hold%0d got=%b exp=%b", k, obs(), 11'd0);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== 11'b00000000001) begin
      failures++;
      $display("FAIL rst_mid_release got=%b exp=%b", obs(), 11'b1);
    end
  endtask

  task automatic test_rotate();
    logic [3:0] exp_q;
    run_cmd(2'b01, 4'b1000, 3'd0, 1'b0, 1'b0, 1'b0, "rot_ld1");
    run_cmd(2'b10, 4'b0000, 3'd4, 1'b0, 1'b1, 1'b0, "rot_left");
    exp_q = ROT ? 4'b1000 : 4'b0000;
    checks++;
    if (q !== exp_q) begin
      failures++;
      $display("FAIL rot_left_q got=%b exp=%b", q, exp_q);
    end
    run_cmd(2'b01, 4'b0001, 3'd0, 1'b0, 1'b0, 1'b0, "rot_ld2");
    run_cmd(2'b11, 4'b0000, 3'd4, 1'b1, 1'b1, 1'b0, "rot_right");
    exp_q = ROT ? 4'b0001 : 4'b1111;
    checks++;
    if (q !== exp_q) begin
      failures++;
      $display("FAIL rot_right_q got=%b exp=%b", q, exp_q);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_cmd(2'($urandom_range(3)), 4'($urandom_range(15)),
              3'($urandom_range(7)), 1'($urandom_range(1)),
              1'($urandom_range(1)), 1'($urandom_range(1)), "rand");
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_shift_left();
    test_zero_count();
    test_back_to_back();
    test_reset_mid();
    test_rotate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
